// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;
  localparam int unsigned IDX_WIDTH      = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream: byte index
// counter, per-lane byte placement and a word-complete flag.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [BYTE_WIDTH-1:0] data,
  output logic [WORD_WIDTH-1:0] word_c,
  output logic                  full_c
);

  logic [IDX_WIDTH-1:0]  idx_q;
  logic [WORD_WIDTH-1:0] word_q;

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    word_c = word_q;
    word_c[idx_q*BYTE_WIDTH +: BYTE_WIDTH] = data;
  end

  assign full_c = accept && (idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1));

  // Byte index and partial word; every lane is overwritten before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
    end else if (accept) begin
      idx_q  <= idx_q + IDX_WIDTH'(1);
      word_q <= word_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to lut_ram loader: collects num_words little-endian words
// and writes them to consecutive addresses starting at 0.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a running sum of
// the written words on the checksum output.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [WORD_WIDTH-1:0] data_d;
  logic                  err_d;
  logic                  start_ok;
  logic                  clear;
  logic                  accept;
  logic [WORD_WIDTH-1:0] word_c;
  logic                  full_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_d;
`endif

  assign start_ok = (num_words != '0) && (num_words <= CW'(DEPTH));
  assign accept   = byte_valid && byte_ready;

  imem_word_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .accept (accept),
    .data   (byte_data),
    .word_c (word_c),
    .full_c (full_c)
  );

  // Next-state, address/count and write-data decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = wr_addr;
    data_d  = wr_data;
    err_d   = 1'b0;
    clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    checksum_d = checksum;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            count_d = num_words;
            addr_d  = '0;
            clear   = 1'b1;
            state_d = ST_COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_d = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (full_c) begin
          data_d  = word_c;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d = checksum + wr_data;
`endif
        if (CW'(wr_addr) == count_q - CW'(1)) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = wr_addr + ADDR_WIDTH'(1);
          clear   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_addr    <= addr_d;
      wr_data    <= data_d;
      byte_ready <= (state_d == ST_COLLECT);
      wr_en      <= (state_d == ST_WRITE);
      busy       <= (state_d != ST_IDLE);
      done       <= (state_d == ST_DONE);
      err        <= err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running sum of written words, cleared on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else begin
      checksum <= checksum_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a behavioural lut_ram model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [DEPTH];
  bit          written [DEPTH];
  int          log_addr[$];
  logic [31:0] log_data[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // lut_ram model and event log.
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]     = wr_data;
      written[wr_addr] = 1'b1;
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(wr_data);
    end
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
    for (int i = 0; i < int'(DEPTH); i++) written[i] = 1'b0;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = (AW+1)'(n);
    step();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      step();
      n++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_timeout: got 0 want 1 within 20 cycles");
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: got %b want 1 within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    #12;
    vectors++; if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    vectors++; if (wr_en !== 1'b0)      begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    vectors++; if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    vectors++; if (wr_addr !== '0 || wr_data !== 32'h0) begin miscompares++; $display("FAIL reset_wr_port: got %h/%h want 0/0", wr_addr, wr_data); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    clear_log();
    do_start(1);
    vectors++; if ({busy, byte_ready} !== 2'b11) begin miscompares++; $display("FAIL single_collect: got %b want 11", {busy, byte_ready}); end
    send_word(32'h00000013, 0);
    vectors++; if (wr_en !== 1'b1 || wr_addr !== AW'(0) || wr_data !== 32'h00000013) begin
      miscompares++; $display("FAIL single_write: got en=%b addr=%h data=%h want en=1 addr=0 data=00000013", wr_en, wr_addr, wr_data);
    end
    step();
    vectors++; if (done !== 1'b1 || wr_en !== 1'b0) begin miscompares++; $display("FAIL single_done: got done=%b en=%b want done=1 en=0", done, wr_en); end
    step();
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL single_idle: got %b want 00", {busy, done}); end
    vectors++; if (log_addr.size() != 1) begin miscompares++; $display("FAIL single_wr_count: got %0d want 1", log_addr.size()); end
  endtask

  task automatic test_stall();
    logic [31:0] exp [3];
    exp[0] = 32'h04030201; exp[1] = 32'h08070605; exp[2] = 32'h0C0B0A09;
    clear_log();
    do_start(3);
    start = 1'b1; num_words = '0;   // must be ignored while busy
    send_word(exp[0], 3);
    start = 1'b0;
    send_word(exp[1], 3);
    send_word(exp[2], 3);
    wait_done(10);
    step();
    vectors++; if (log_addr.size() != 3) begin miscompares++; $display("FAIL stall_wr_count: got %0d want 3", log_addr.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      vectors++;
      if (log_addr[i] != i || log_data[i] !== exp[i] || mem[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL stall_word%0d: got addr=%0d data=%h mem=%h want addr=%0d data=%h", i, log_addr[i], log_data[i], mem[i], i, exp[i]);
      end
    end
    vectors++; if (err_cnt != 0 || done_cnt != 1) begin miscompares++; $display("FAIL stall_events: got err=%0d done=%0d want 0/1", err_cnt, done_cnt); end
  endtask

  task automatic test_reject();
    int bad [2];
    bad[0] = 0; bad[1] = int'(DEPTH) + 1;
    clear_log();
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i]);
      vectors++; if ({err, busy} !== 2'b10) begin miscompares++; $display("FAIL reject%0d_pulse: got err/busy=%b want 10", i, {err, busy}); end
      step();
      vectors++; if ({err, busy} !== 2'b00) begin miscompares++; $display("FAIL reject%0d_after: got err/busy=%b want 00", i, {err, busy}); end
    end
    vectors++; if (log_addr.size() != 0 || err_cnt != 2) begin miscompares++; $display("FAIL reject_events: got writes=%0d errs=%0d want 0/2", log_addr.size(), err_cnt); end
  endtask

  task automatic test_full_depth();
    int bad = 0;
    clear_log();
    do_start(int'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) send_word(32'(i) * 32'h01000193 + 32'h7, 0);
    wait_done(10);
    step(); step();
    vectors++; if (log_addr.size() != int'(DEPTH)) begin miscompares++; $display("FAIL full_wr_count: got %0d want %0d", log_addr.size(), DEPTH); end
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] != i || log_data[i] !== 32'(i) * 32'h01000193 + 32'h7) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL full_words: got %0d bad writes want 0", bad); end
    vectors++; if (log_addr.size() > 0 && log_addr[log_addr.size()-1] != int'(DEPTH) - 1) begin
      miscompares++; $display("FAIL full_last_addr: got %0d want %0d", log_addr[log_addr.size()-1], DEPTH - 1);
    end
    vectors++; if (done_cnt != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL full_done: got done=%0d busy=%b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_reset_abort();
    clear_log();
    do_start(2);
    send_word(32'h11223344, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({busy, byte_ready, wr_en, done, err} !== 5'b0) begin
      miscompares++; $display("FAIL abort_flags: got %b want 00000", {busy, byte_ready, wr_en, done, err});
    end
    vectors++; if (wr_addr !== '0 || wr_data !== 32'h0) begin miscompares++; $display("FAIL abort_wr_port: got %h/%h want 0/0", wr_addr, wr_data); end
    step();
    rst_n = 1'b1;
    byte_valid = 1'b1; byte_data = 8'hCC;
    for (int i = 0; i < 8; i++) step();
    byte_valid = 1'b0;
    vectors++; if (log_addr.size() != 1 || written[1]) begin miscompares++; $display("FAIL abort_writes: got %0d writes addr1=%b want 1/0", log_addr.size(), written[1]); end
    vectors++; if (mem[0] !== 32'h11223344) begin miscompares++; $display("FAIL abort_mem0: got %h want 11223344", mem[0]); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start(2);
    send_word(32'hFFFFFFFF, 1);
    send_word(32'h00000002, 1);
    wait_done(10);
    vectors++; if (checksum !== 32'h00000001) begin miscompares++; $display("FAIL checksum: got %h want 00000001", checksum); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_reject();
    test_full_depth();
    test_reset_abort();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the target lut_ram.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), width of the lut_ram write address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request to begin a load; sampled in IDLE only.
REQ-006 num_words  input  ADDR_WIDTH+1  word count to load; sampled with start.
REQ-007 byte_valid  input  1  upstream byte-stream valid.
REQ-008 byte_data  input  8  upstream byte.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 wr_en  output  1  lut_ram write enable.
REQ-011 wr_addr  output  ADDR_WIDTH  lut_ram write address.
REQ-012 wr_data  output  32  lut_ram write data.
REQ-013 busy  output  1  high in any state other than IDLE; used to hold the core.
REQ-014 done  output  1  one-cycle pulse when the last word has been written.
REQ-015 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE and DONE.
REQ-017 IDLE: if start=1 and 1<=num_words<=DEPTH, latch num_words, clear the word address and byte index, and go to COLLECT next cycle.
REQ-018 IDLE: if start=1 and num_words is 0 or greater than DEPTH, pulse err for the next cycle and stay in IDLE.
REQ-019 COLLECT: byte_ready=1; a byte transfers only on a cycle with byte_valid=1 and byte_ready=1.
REQ-020 Each byte SHALL fill the word little-endian: the 1st byte goes to [7:0] and the 4th byte to [31:24].
REQ-021 On the 4th transfer, go to WRITE next cycle; byte_ready=0 in every state except COLLECT.
REQ-022 WRITE: wr_en=1 for exactly one cycle, with wr_addr = current address and wr_data = assembled word; wr_en=0 in every other state.
REQ-023 WRITE: if address = latched count-1, go to DONE; otherwise increment the address, clear the byte index, and return to COLLECT.
REQ-024 DONE: done=1 for one cycle, then go to IDLE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 The lut_ram write completes at the clk edge ending WRITE, so the word is readable via rd_addr the following cycle.
REQ-027 Between accepted bytes, byte_valid=0 SHALL stall without loss; no bubble limit applies.

Reset
REQ-028 rst_n=0 SHALL force, asynchronously: state IDLE; byte_ready, wr_en, busy, done, err = 0; wr_addr, wr_data, byte index, latched count = 0.
REQ-029 Reset during COLLECT or WRITE SHALL abort the load with no further write; words already written remain in lut_ram.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined: add output checksum[31:0], equal to the sum mod 2^32 of all written words, cleared on an accepted start and valid from the done pulse until the next accepted start; reset value 0.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN: the checksum port and logic are absent; all other behaviour is identical.

Structure
REQ-032 Package imem_loader_pkg SHALL hold the state enum typedef and the constants BYTES_PER_WORD=4 and BYTE_WIDTH=8.
REQ-033 Byte-to-word packing SHALL be a sub-module imem_word_packer: byte index counter, lane shift, and word_full flag.
REQ-034 Top-level outputs wr_en, wr_addr and wr_data SHALL connect directly to the lut_ram write port.

Verification
REQ-035 start, num_words=1; bytes 0x13,0x00,0x00,0x00 -> one wr_en pulse: addr 0, data 0x00000013; done pulses 1 cycle later; busy=0 after.
REQ-036 num_words=3; 12 bytes, with byte_valid deasserted randomly -> writes to addr 0,1,2 with the correct little-endian words; lut_ram.mem matches each write.
REQ-037 start with num_words=0, and start with num_words=DEPTH+1 -> err pulses, busy stays 0, no wr_en.
REQ-038 num_words=DEPTH -> last write at addr DEPTH-1; no address wrap; done pulses once.
REQ-039 rst_n=0 after 2 bytes of word 1 -> outputs go to 0 immediately; word 0 is retained in lut_ram; no write to addr 1.
REQ-040 With IMEM_LOADER_CHECKSUM_EN: words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 at done.
